// File: rtl/mul_wb_queue.sv
// Result buffer behind the non-stallable multiply unit: captures every completion into a
// small FIFO, drains it over a valid/ready writeback handshake, and issues credits upstream.
module mul_wb_queue #(
    parameter int DEPTH    = 4,
    parameter int PIPE_LAT = 4,
    parameter int M_WIDTH  = 64,
    parameter int ROB_W    = 6,
    parameter int PRF_W    = 7
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       issue_go,
    input  logic                       mul_complete,
    input  logic [M_WIDTH-1:0]         mul_y,
    input  logic [ROB_W-1:0]           mul_rob_ptr,
    input  logic                       mul_prf_ptr_val,
    input  logic [PRF_W-1:0]           mul_prf_ptr,
    output logic                       wb_valid,
    input  logic                       wb_ready,
    output logic [M_WIDTH-1:0]         wb_data,
    output logic [ROB_W-1:0]           wb_rob_ptr,
    output logic                       wb_prf_ptr_val,
    output logic [PRF_W-1:0]           wb_prf_ptr,
    output logic                       mul_can_issue,
    output logic [$clog2(DEPTH):0]     occupancy,
    output logic                       overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] OCC_FULL   = CW'(DEPTH);
    localparam logic [CW:0]   CREDIT_LIM = (CW + 1)'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);

    logic [M_WIDTH-1:0] r_y_mem   [DEPTH];
    logic [ROB_W-1:0]   r_rob_mem [DEPTH];
    logic               r_pval_mem[DEPTH];
    logic [PRF_W-1:0]   r_prf_mem [DEPTH];

    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [CW-1:0] r_occ;
    logic [CW-1:0] r_inflight;
    logic          r_overflow;

    logic          w_vld;
    logic          w_enq;
    logic          w_deq;
    logic          w_full;
    logic          w_wr;
    logic          w_credit;
    logic [CW:0]   w_commit;

    // Completions with nothing in flight are leftovers from before a reset and are dropped.
    assign w_vld    = (r_occ != '0);
    assign w_enq    = mul_complete && (r_inflight != '0);
    assign w_deq    = w_vld && wb_ready;
    assign w_full   = (r_occ == OCC_FULL);
    assign w_wr     = w_enq && (!w_full || w_deq);
    assign w_commit = {1'b0, r_occ} + {1'b0, r_inflight};
    assign w_credit = (w_commit < CREDIT_LIM);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_occ      <= '0;
            r_inflight <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr) begin
                r_tail <= r_tail + PTR_ONE;
            end
            if (w_deq) begin
                r_head <= r_head + PTR_ONE;
            end
            case ({w_wr, w_deq})
                2'b10:   r_occ <= r_occ + CNT_ONE;
                2'b01:   r_occ <= r_occ - CNT_ONE;
                default: r_occ <= r_occ;
            endcase
            case ({issue_go, w_enq})
                2'b10:   r_inflight <= r_inflight + CNT_ONE;
                2'b01:   r_inflight <= r_inflight - CNT_ONE;
                default: r_inflight <= r_inflight;
            endcase
            if ((w_enq && w_full && !w_deq) || (issue_go && !w_credit)) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // At full with a same-cycle dequeue the tail slot is the head slot; the head is read
    // before the edge, so overwriting it here is safe.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_y_mem[r_tail]    <= mul_y;
            r_rob_mem[r_tail]  <= mul_rob_ptr;
            r_pval_mem[r_tail] <= mul_prf_ptr_val;
            r_prf_mem[r_tail]  <= mul_prf_ptr;
        end
    end

    // Storage is not reset, so the head fields are masked while the queue is empty.
    assign wb_valid       = w_vld;
    assign wb_data        = w_vld ? r_y_mem[r_head]    : '0;
    assign wb_rob_ptr     = w_vld ? r_rob_mem[r_head]  : '0;
    assign wb_prf_ptr_val = w_vld ? r_pval_mem[r_head] : 1'b0;
    assign wb_prf_ptr     = w_vld ? r_prf_mem[r_head]  : '0;
    assign mul_can_issue  = w_credit;
    assign occupancy      = r_occ;
    assign overflow       = r_overflow;

`ifndef SYNTHESIS
    logic [PIPE_LAT-1:0] r_issue_hist;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_issue_hist <= '0;
        end else begin
            r_issue_hist <= {r_issue_hist[PIPE_LAT-1:0], issue_go} >> 0;
        end
    end

    a_fixed_latency: assert property (@(posedge clk) disable iff (reset)
        (mul_complete && (r_inflight != '0)) |-> r_issue_hist[PIPE_LAT-1]);

    a_occ_bound: assert property (@(posedge clk) disable iff (reset)
        r_occ <= OCC_FULL);

    a_head_stable: assert property (@(posedge clk) disable iff (reset)
        (wb_valid && !wb_ready) |=> (wb_valid && $stable(wb_data) && $stable(wb_rob_ptr)
                                     && $stable(wb_prf_ptr_val) && $stable(wb_prf_ptr)));
`endif

endmodule

// File: tb/tb_mul_wb_queue.sv
// Directed bench for mul_wb_queue with a fixed-latency multiply pipe model driving completions.
module tb_mul_wb_queue;

    localparam int DEPTH    = 4;
    localparam int PIPE_LAT = 4;
    localparam int MW       = 32;
    localparam int RW       = 6;
    localparam int PW       = 7;
    localparam int CW       = $clog2(DEPTH) + 1;

    logic          clk      = 1'b0;
    logic          reset    = 1'b1;
    logic          issue_go = 1'b0;
    logic          wb_ready = 1'b0;
    logic [MW-1:0] iss_y    = '0;
    logic [RW-1:0] iss_rob  = '0;
    logic [PW-1:0] iss_prf  = '0;
    logic          iss_val  = 1'b0;

    logic [PIPE_LAT-1:0] pv = '0;
    logic [MW-1:0]       py [PIPE_LAT] = '{default: '0};
    logic [RW-1:0]       pr [PIPE_LAT] = '{default: '0};
    logic [PW-1:0]       pp [PIPE_LAT] = '{default: '0};
    logic [PIPE_LAT-1:0] pvl = '0;

    logic          mul_complete;
    logic [MW-1:0] mul_y;
    logic [RW-1:0] mul_rob_ptr;
    logic          mul_prf_ptr_val;
    logic [PW-1:0] mul_prf_ptr;
    logic          wb_valid;
    logic [MW-1:0] wb_data;
    logic [RW-1:0] wb_rob_ptr;
    logic          wb_prf_ptr_val;
    logic [PW-1:0] wb_prf_ptr;
    logic          mul_can_issue;
    logic [CW-1:0] occupancy;
    logic          overflow;

    int total = 0;
    int bad   = 0;
    int xfers = 0;

    always #5 clk = ~clk;

    // Multiply unit model: an issue sampled at edge N completes (is sampled) at edge N+PIPE_LAT.
    always @(posedge clk) begin
        pv  <= {pv[PIPE_LAT-2:0], issue_go};
        pvl <= {pvl[PIPE_LAT-2:0], iss_val};
        py[0] <= iss_y;
        pr[0] <= iss_rob;
        pp[0] <= iss_prf;
        for (int k = 1; k < PIPE_LAT; k++) begin
            py[k] <= py[k-1];
            pr[k] <= pr[k-1];
            pp[k] <= pp[k-1];
        end
    end

    assign mul_complete    = pv[PIPE_LAT-1];
    assign mul_y           = py[PIPE_LAT-1];
    assign mul_rob_ptr     = pr[PIPE_LAT-1];
    assign mul_prf_ptr_val = pvl[PIPE_LAT-1];
    assign mul_prf_ptr     = pp[PIPE_LAT-1];

    mul_wb_queue #(
        .DEPTH   (DEPTH),
        .PIPE_LAT(PIPE_LAT),
        .M_WIDTH (MW),
        .ROB_W   (RW),
        .PRF_W   (PW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .issue_go       (issue_go),
        .mul_complete   (mul_complete),
        .mul_y          (mul_y),
        .mul_rob_ptr    (mul_rob_ptr),
        .mul_prf_ptr_val(mul_prf_ptr_val),
        .mul_prf_ptr    (mul_prf_ptr),
        .wb_valid       (wb_valid),
        .wb_ready       (wb_ready),
        .wb_data        (wb_data),
        .wb_rob_ptr     (wb_rob_ptr),
        .wb_prf_ptr_val (wb_prf_ptr_val),
        .wb_prf_ptr     (wb_prf_ptr),
        .mul_can_issue  (mul_can_issue),
        .occupancy      (occupancy),
        .overflow       (overflow)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_iss(input logic go, input logic [MW-1:0] y, input logic [RW-1:0] r,
                           input logic [PW-1:0] p, input logic v);
        issue_go = go;
        iss_y    = y;
        iss_rob  = r;
        iss_prf  = p;
        iss_val  = v;
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        chk("rst_valid", 64'(wb_valid), 64'(0));
        chk("rst_overflow", 64'(overflow), 64'(0));
        chk("rst_credit", 64'(mul_can_issue), 64'(1));
        chk("rst_occ", 64'(occupancy), 64'(0));
        chk("rst_data", 64'(wb_data), 64'(0));
        chk("rst_rob", 64'(wb_rob_ptr), 64'(0));
        chk("rst_pval", 64'(wb_prf_ptr_val), 64'(0));
        chk("rst_prf", 64'(wb_prf_ptr), 64'(0));
        reset = 1'b0;

        // Single op end to end, ready held high
        wb_ready = 1'b1;
        set_iss(1'b1, 32'h1234, 6'd5, 7'd9, 1'b1);
        chk("t1_credit_pre", 64'(mul_can_issue), 64'(1));
        tick();
        set_iss(1'b0, '0, '0, '0, 1'b0);
        chk("t1_credit_e0", 64'(mul_can_issue), 64'(1));
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t1_no_early_valid", 64'(wb_valid), 64'(0));
            chk("t1_credit_wait", 64'(mul_can_issue), 64'(1));
        end
        tick();
        chk("t1_valid", 64'(wb_valid), 64'(1));
        chk("t1_data", 64'(wb_data), 64'(32'h1234));
        chk("t1_rob", 64'(wb_rob_ptr), 64'(5));
        chk("t1_prf", 64'(wb_prf_ptr), 64'(9));
        chk("t1_pval", 64'(wb_prf_ptr_val), 64'(1));
        chk("t1_occ1", 64'(occupancy), 64'(1));
        chk("t1_credit_q", 64'(mul_can_issue), 64'(1));
        tick();
        chk("t1_drained_valid", 64'(wb_valid), 64'(0));
        chk("t1_drained_occ", 64'(occupancy), 64'(0));
        chk("t1_credit_end", 64'(mul_can_issue), 64'(1));

        // Fill with ready low, then drain in order
        wb_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("t2_credit_before_issue", 64'(mul_can_issue), 64'(1));
            set_iss(1'b1, 32'(32'hA0 + i), RW'(i + 1), PW'(10 + i), i[0]);
            tick();
        end
        set_iss(1'b0, '0, '0, '0, 1'b0);
        chk("t2_credit_exhausted", 64'(mul_can_issue), 64'(0));
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t2_credit_held", 64'(mul_can_issue), 64'(0));
        end
        chk("t2_occ_full", 64'(occupancy), 64'(4));
        chk("t2_no_overflow", 64'(overflow), 64'(0));
        chk("t2_valid", 64'(wb_valid), 64'(1));
        wb_ready = 1'b1;
        chk("t2_credit_not_comb", 64'(mul_can_issue), 64'(0));
        for (int i = 0; i < 4; i++) begin
            chk("t2_order_data", 64'(wb_data), 64'(32'hA0 + i));
            chk("t2_order_rob", 64'(wb_rob_ptr), 64'(i + 1));
            chk("t2_order_prf", 64'(wb_prf_ptr), 64'(10 + i));
            chk("t2_order_pval", 64'(wb_prf_ptr_val), 64'(i[0]));
            tick();
            chk("t2_occ_drain", 64'(occupancy), 64'(3 - i));
            chk("t2_credit_back", 64'(mul_can_issue), 64'(1));
        end
        wb_ready = 1'b0;

        // Forced issue past credit, then enqueue+dequeue at full across the wrap
        for (int i = 0; i < 5; i++) begin
            if (i == 4) begin
                chk("t3_credit_zero", 64'(mul_can_issue), 64'(0));
                chk("t3_overflow_before", 64'(overflow), 64'(0));
            end
            set_iss(1'b1, 32'(32'hB0 + i), RW'(20 + i), PW'(40 + i), 1'b1);
            tick();
        end
        set_iss(1'b0, '0, '0, '0, 1'b0);
        chk("t3_overflow_set", 64'(overflow), 64'(1));
        repeat (3) tick();
        chk("t3_occ_full", 64'(occupancy), 64'(4));
        chk("t3_head_b0", 64'(wb_data), 64'(32'hB0));
        wb_ready = 1'b1;
        tick();
        chk("t3_occ_full_simul", 64'(occupancy), 64'(4));
        chk("t3_overflow_sticky", 64'(overflow), 64'(1));
        for (int i = 1; i < 5; i++) begin
            chk("t3_wrap_data", 64'(wb_data), 64'(32'hB0 + i));
            chk("t3_wrap_rob", 64'(wb_rob_ptr), 64'(20 + i));
            tick();
        end
        chk("t3_occ_empty", 64'(occupancy), 64'(0));
        chk("t3_valid_empty", 64'(wb_valid), 64'(0));
        chk("t3_overflow_still", 64'(overflow), 64'(1));
        wb_ready = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t4_overflow_cleared", 64'(overflow), 64'(0));
        chk("t4_occ_cleared", 64'(occupancy), 64'(0));

        // Stall pattern with three queued
        for (int i = 0; i < 3; i++) begin
            set_iss(1'b1, 32'(32'hC0 + i), RW'(30 + i), PW'(50 + i), ~i[0]);
            tick();
        end
        set_iss(1'b0, '0, '0, '0, 1'b0);
        repeat (4) tick();
        chk("t5_occ3", 64'(occupancy), 64'(3));
        xfers = 0;
        for (int i = 0; i < 8; i++) begin
            wb_ready = i[0];
            if (xfers < 3) begin
                chk("t5_valid", 64'(wb_valid), 64'(1));
                chk("t5_data", 64'(wb_data), 64'(32'hC0 + xfers));
                chk("t5_rob", 64'(wb_rob_ptr), 64'(30 + xfers));
            end else begin
                chk("t5_valid_empty", 64'(wb_valid), 64'(0));
            end
            tick();
            if (wb_ready && xfers < 3) xfers++;
            chk("t5_occ", 64'(occupancy), 64'(3 - xfers));
        end
        chk("t5_occ_end", 64'(occupancy), 64'(0));

        // Reset with two queued and two in flight
        wb_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_iss(1'b1, 32'(32'hD0 + i), RW'(i), PW'(60 + i), 1'b1);
            tick();
        end
        set_iss(1'b0, '0, '0, '0, 1'b0);
        tick();
        tick();
        chk("t6_occ2", 64'(occupancy), 64'(2));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t6_valid", 64'(wb_valid), 64'(0));
        chk("t6_data", 64'(wb_data), 64'(0));
        chk("t6_rob", 64'(wb_rob_ptr), 64'(0));
        chk("t6_pval", 64'(wb_prf_ptr_val), 64'(0));
        chk("t6_prf", 64'(wb_prf_ptr), 64'(0));
        chk("t6_occ", 64'(occupancy), 64'(0));
        chk("t6_overflow", 64'(overflow), 64'(0));
        chk("t6_credit", 64'(mul_can_issue), 64'(1));
        tick();
        chk("t6_late_occ", 64'(occupancy), 64'(0));
        chk("t6_late_valid", 64'(wb_valid), 64'(0));
        chk("t6_late_overflow", 64'(overflow), 64'(0));
        tick();
        chk("t6_late_occ2", 64'(occupancy), 64'(0));

        // Enqueue and dequeue together at occupancy 1
        wb_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            set_iss(1'b1, 32'(32'hE0 + i), RW'(40 + i), PW'(70 + i), 1'b0);
            tick();
        end
        set_iss(1'b0, '0, '0, '0, 1'b0);
        repeat (3) tick();
        chk("t7_occ1_a", 64'(occupancy), 64'(1));
        chk("t7_head_e0", 64'(wb_data), 64'(32'hE0));
        tick();
        chk("t7_occ1_b", 64'(occupancy), 64'(1));
        chk("t7_head_e1", 64'(wb_data), 64'(32'hE1));
        chk("t7_rob_e1", 64'(wb_rob_ptr), 64'(41));
        tick();
        chk("t7_occ0", 64'(occupancy), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
